// File: rtl/mem_bus_ctrl.sv
// Master-side controller for a 32x8 memory with a shared tri-state data bus.
// Define MEM_CTRL_TURNAROUND_EN to add one dead bus cycle (TURN) after every write.
module mem_bus_ctrl #(
   parameter int ADDR_W    = 5,
   parameter int DATA_W    = 8,
   parameter int READ_WAIT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              mem_en,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   inout  wire  [DATA_W-1:0] mem_data,
   output logic              busy
);

   localparam int              CNT_W        = 3;
   localparam logic [CNT_W-1:0] RD_WAIT_INIT = CNT_W'(READ_WAIT);

`ifdef MEM_CTRL_TURNAROUND_EN
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WR   = 2'd1,
      ST_RD   = 2'd2,
      ST_TURN = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WR   = 2'd1,
      ST_RD   = 2'd2
   } state_t;
`endif

   state_t              state_reg, state_next;
   logic [ADDR_W-1:0]   addr_reg, addr_next;
   logic [DATA_W-1:0]   wdata_reg, wdata_next;
   logic [CNT_W-1:0]    cnt_reg, cnt_next;
   logic                rsp_valid_reg, rsp_valid_next;
   logic [DATA_W-1:0]   rsp_rdata_reg, rsp_rdata_next;
   logic                drive_en;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (req_valid) begin
               state_next = req_we ? ST_WR : ST_RD;
            end
         end
         ST_WR: begin
`ifdef MEM_CTRL_TURNAROUND_EN
            state_next = ST_TURN;
`else
            state_next = ST_IDLE;
`endif
         end
         ST_RD: begin
            if (cnt_reg == '0) begin
               state_next = ST_IDLE;
            end
         end
`ifdef MEM_CTRL_TURNAROUND_EN
         ST_TURN: state_next = ST_IDLE;
`endif
         default: state_next = ST_IDLE;
      endcase
   end

   // Output decode: everything facing the memory comes from state or latched registers
   always_comb begin
      req_ready = 1'b0;
      mem_en    = 1'b0;
      mem_rw    = 1'b0;
      drive_en  = 1'b0;
      case (state_reg)
         ST_IDLE: req_ready = 1'b1;
         ST_WR: begin
            mem_en   = 1'b1;
            mem_rw   = 1'b1;
            drive_en = !rst;
         end
         ST_RD:   mem_en = 1'b1;
         default: ;
      endcase
   end

   assign busy      = (state_reg != ST_IDLE);
   assign mem_addr  = addr_reg;
   assign rsp_valid = rsp_valid_reg;
   assign rsp_rdata = rsp_rdata_reg;

   // Bus is only ever driven by this side during the single WR cycle
   for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bus_drv
      assign mem_data[gi] = drive_en ? wdata_reg[gi] : 1'bz;
   end

   // Request latch, read-wait counter and response path
   always_comb begin
      addr_next      = addr_reg;
      wdata_next     = wdata_reg;
      cnt_next       = cnt_reg;
      rsp_valid_next = 1'b0;
      rsp_rdata_next = rsp_rdata_reg;
      case (state_reg)
         ST_IDLE: begin
            if (req_valid) begin
               addr_next  = req_addr;
               wdata_next = req_wdata;
               cnt_next   = RD_WAIT_INIT;
            end
         end
         ST_WR: rsp_valid_next = 1'b1;
         ST_RD: begin
            if (cnt_reg == '0) begin
               rsp_valid_next = 1'b1;
               rsp_rdata_next = mem_data;
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_reg      <= '0;
         wdata_reg     <= '0;
         cnt_reg       <= '0;
         rsp_valid_reg <= 1'b0;
         rsp_rdata_reg <= '0;
      end else begin
         addr_reg      <= addr_next;
         wdata_reg     <= wdata_next;
         cnt_reg       <= cnt_next;
         rsp_valid_reg <= rsp_valid_next;
         rsp_rdata_reg <= rsp_rdata_next;
      end
   end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: behavioural 32x8 tri-state memory plus an expected-image model.
`timescale 1ns/1ps
module tb_mem_bus_ctrl;
   localparam int ADDR_W = 5;
   localparam int DATA_W = 8;
   parameter  int READ_WAIT = 1;
`ifdef MEM_CTRL_TURNAROUND_EN
   localparam int WR_SPACING = 3;
`else
   localparam int WR_SPACING = 2;
`endif
   localparam int RD_LAT = READ_WAIT + 2;
   localparam int WR_LAT = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              mem_en;
   logic              mem_rw;
   logic [ADDR_W-1:0] mem_addr;
   wire  [DATA_W-1:0] mem_data;
   logic              busy;

   int total = 0;
   int bad   = 0;

   logic [7:0] seed_vals [32];
   logic [7:0] ref_mem   [32];
   logic [7:0] mem_arr   [32];
   logic       mem_load;

   always #5 clk = ~clk;

   mem_bus_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_WAIT(READ_WAIT)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .mem_en(mem_en),
      .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy)
   );

   // Behavioural memory: writes at the edge, drives the bus combinationally on reads
   always @(posedge clk) begin
      if (mem_load) begin
         for (int i = 0; i < 32; i++) mem_arr[i] <= seed_vals[i];
      end else if (mem_en && mem_rw) begin
         mem_arr[mem_addr] <= mem_data;
      end
   end
   assign mem_data = (mem_en && !mem_rw) ? mem_arr[mem_addr] : 8'hzz;

   // One request; records the first-cycle bus view and the response timing
   task automatic run_txn(input logic we, input logic [4:0] a, input logic [7:0] d,
                          output int rsp_k, output int pulses, output logic [7:0] rdata,
                          output logic en1, output logic rw1, output logic [4:0] addr1,
                          output logic [7:0] data1, output logic acc_ok);
      int guard = 0;
      @(negedge clk);
      while (!req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      acc_ok    = req_ready;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      @(posedge clk);
      rsp_k  = -1;
      pulses = 0;
      rdata  = '0;
      en1    = 1'b0;
      rw1    = 1'b0;
      addr1  = '0;
      data1  = '0;
      for (int k = 1; k <= RD_LAT + 8; k++) begin
         @(negedge clk);
         if (k == 1) begin
            req_valid = 1'b0;
            en1   = mem_en;
            rw1   = mem_rw;
            addr1 = mem_addr;
            data1 = mem_data;
         end
         if (rsp_valid) begin
            pulses++;
            if (rsp_k < 0) begin
               rsp_k = k;
               rdata = rsp_rdata;
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; mem_load = 1'b1; req_valid = 1'b0; req_we = 1'b0;
      req_addr = '0; req_wdata = '0;
      for (int i = 0; i < 32; i++) begin
         seed_vals[i] = 8'($urandom);
         ref_mem[i]   = seed_vals[i];
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      mem_load = 1'b0;
      total++; if (mem_en !== 1'b0)  begin bad++; $display("FAIL reset_mem_en got %0b want 0", mem_en); end
      total++; if (mem_rw !== 1'b0)  begin bad++; $display("FAIL reset_mem_rw got %0b want 0", mem_rw); end
      total++; if (mem_addr !== 5'd0) begin bad++; $display("FAIL reset_mem_addr got %0h want 0", mem_addr); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got %0b want 0", rsp_valid); end
      total++; if (rsp_rdata !== 8'h00) begin bad++; $display("FAIL reset_rsp_rdata got %0h want 0", rsp_rdata); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %0b want 0", busy); end
      rst = 1'b0;
      @(negedge clk);
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got %0b want 1", req_ready); end
      $display("reset: released");
   endtask

   task automatic test_write_read();
      int k, p; logic [7:0] rd, d1; logic e1, r1, ok; logic [4:0] a1;
      run_txn(1'b1, 5'd1, 8'h02, k, p, rd, e1, r1, a1, d1, ok);
      ref_mem[1] = 8'h02;
      $display("txn WR addr=01 data=02 rsp_k=%0d", k);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL wr_accept got %0b want 1", ok); end
      total++; if (e1 !== 1'b1) begin bad++; $display("FAIL wr_mem_en got %0b want 1", e1); end
      total++; if (r1 !== 1'b1) begin bad++; $display("FAIL wr_mem_rw got %0b want 1", r1); end
      total++; if (a1 !== 5'd1) begin bad++; $display("FAIL wr_mem_addr got %0h want 1", a1); end
      total++; if (d1 !== 8'h02) begin bad++; $display("FAIL wr_mem_data got %0h want 02", d1); end
      total++; if (k != WR_LAT) begin bad++; $display("FAIL wr_latency got %0d want %0d", k, WR_LAT); end
      total++; if (p != 1) begin bad++; $display("FAIL wr_pulses got %0d want 1", p); end
      run_txn(1'b0, 5'd1, 8'h00, k, p, rd, e1, r1, a1, d1, ok);
      $display("txn RD addr=01 data=%02h rsp_k=%0d", rd, k);
      total++; if (rd !== ref_mem[1]) begin bad++; $display("FAIL rd_data got %0h want %0h", rd, ref_mem[1]); end
      total++; if (k != RD_LAT) begin bad++; $display("FAIL rd_latency got %0d want %0d", k, RD_LAT); end
      total++; if (p != 1) begin bad++; $display("FAIL rd_pulses got %0d want 1", p); end
   endtask

   task automatic test_unwritten();
      int k, p; logic [7:0] rd, d1; logic e1, r1, ok; logic [4:0] a1;
      run_txn(1'b0, 5'd2, 8'h00, k, p, rd, e1, r1, a1, d1, ok);
      $display("txn RD addr=02 data=%02h rsp_k=%0d", rd, k);
      total++; if (e1 !== 1'b1) begin bad++; $display("FAIL unw_mem_en got %0b want 1", e1); end
      total++; if (r1 !== 1'b0) begin bad++; $display("FAIL unw_mem_rw got %0b want 0", r1); end
      total++; if (a1 !== 5'd2) begin bad++; $display("FAIL unw_mem_addr got %0h want 2", a1); end
      total++; if (d1 !== ref_mem[2]) begin bad++; $display("FAIL unw_bus got %0h want %0h", d1, ref_mem[2]); end
      total++; if (rd !== ref_mem[2]) begin bad++; $display("FAIL unw_data got %0h want %0h", rd, ref_mem[2]); end
   endtask

   task automatic test_back_to_back();
      int acc2 = -1; int early_ready = 0; int guard = 0;
      int pk[$]; logic [7:0] pd[$];
      @(negedge clk);
      while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
      req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd1;
      @(posedge clk);
      for (int k = 1; k <= 2 * RD_LAT + 4; k++) begin
         @(negedge clk);
         if (k == 1) req_addr = 5'd31;
         if (rsp_valid) begin pk.push_back(k); pd.push_back(rsp_rdata); end
         if (k < RD_LAT && req_ready) early_ready++;
         if (acc2 < 0 && req_ready && req_valid) acc2 = k;
         else if (acc2 >= 0) req_valid = 1'b0;
      end
      req_valid = 1'b0;
      $display("txn B2B RD addr=01,1f pulses=%0d second_accept=%0d", pk.size(), acc2);
      total++; if (early_ready != 0) begin bad++; $display("FAIL b2b_ready_low got %0d want 0", early_ready); end
      total++; if (acc2 != RD_LAT) begin bad++; $display("FAIL b2b_accept got %0d want %0d", acc2, RD_LAT); end
      total++; if (pk.size() != 2) begin bad++; $display("FAIL b2b_pulses got %0d want 2", pk.size()); end
      if (pk.size() == 2) begin
         total++; if (pk[0] != RD_LAT) begin bad++; $display("FAIL b2b_first got %0d want %0d", pk[0], RD_LAT); end
         total++; if (pk[1] - pk[0] != RD_LAT) begin bad++; $display("FAIL b2b_gap got %0d want %0d", pk[1] - pk[0], RD_LAT); end
         total++; if (pd[0] !== ref_mem[1]) begin bad++; $display("FAIL b2b_data0 got %0h want %0h", pd[0], ref_mem[1]); end
         total++; if (pd[1] !== ref_mem[31]) begin bad++; $display("FAIL b2b_data1 got %0h want %0h", pd[1], ref_mem[31]); end
      end
   endtask

   task automatic test_reset_mid_read();
      int pulses = 0; int guard = 0;
      @(negedge clk);
      while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
      req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd5;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL rstrd_mem_en got %0b want 0", mem_en); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstrd_busy got %0b want 0", busy); end
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rstrd_ready got %0b want 1", req_ready); end
      total++; if (rsp_rdata !== 8'h00) begin bad++; $display("FAIL rstrd_rdata got %0h want 0", rsp_rdata); end
      for (int k = 0; k < RD_LAT + 6; k++) begin
         if (rsp_valid) pulses++;
         @(negedge clk);
      end
      $display("txn RD addr=05 dropped by reset pulses=%0d", pulses);
      total++; if (pulses != 0) begin bad++; $display("FAIL rstrd_no_rsp got %0d want 0", pulses); end
   endtask

   task automatic test_write_then_read();
      int acc = -1; int guard = 0; int rk = -1;
      logic [4:0] a; logic [7:0] d; logic [7:0] rd = '0; logic en2 = 1'b1; logic [7:0] bus_rd = '0;
      a = 5'($urandom_range(0, 31));
      d = 8'($urandom);
      @(negedge clk);
      while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
      req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
      ref_mem[a] = d;
      @(posedge clk);
      for (int k = 1; k <= WR_SPACING + RD_LAT + 4; k++) begin
         @(negedge clk);
         if (k == 1) req_we = 1'b0;
         if (k == 2) en2 = mem_en;
         if (acc >= 0 && k == acc + 1) bus_rd = mem_data;
         if (acc >= 0 && rk < 0 && rsp_valid && k > acc) begin rk = k - acc; rd = rsp_rdata; end
         if (acc < 0 && k > 1 && req_ready && req_valid) acc = k;
         else if (acc >= 0) req_valid = 1'b0;
      end
      req_valid = 1'b0;
      $display("txn WR->RD addr=%02h data=%02h read_accept=%0d rsp_k=%0d", a, d, acc, rk);
      total++; if (en2 !== 1'b0) begin bad++; $display("FAIL wtr_dead_en got %0b want 0", en2); end
      total++; if (acc != WR_SPACING) begin bad++; $display("FAIL wtr_spacing got %0d want %0d", acc, WR_SPACING); end
      total++; if (bus_rd !== d) begin bad++; $display("FAIL wtr_bus got %0h want %0h", bus_rd, d); end
      total++; if (rk != RD_LAT) begin bad++; $display("FAIL wtr_latency got %0d want %0d", rk, RD_LAT); end
      total++; if (rd !== d) begin bad++; $display("FAIL wtr_data got %0h want %0h", rd, d); end
   endtask

   task automatic test_random();
      int k, p; logic [7:0] rd, d1; logic e1, r1, ok; logic [4:0] a1;
      logic we; logic [4:0] a; logic [7:0] d;
      for (int n = 0; n < 40; n++) begin
         we = 1'($urandom_range(0, 1));
         a  = (n % 8 == 0) ? 5'd31 : 5'($urandom_range(0, 31));
         d  = 8'($urandom);
         run_txn(we, a, d, k, p, rd, e1, r1, a1, d1, ok);
         $display("txn %0d %s addr=%02h data=%02h rsp_k=%0d", n, we ? "WR" : "RD", a, we ? d : rd, k);
         total++; if (ok !== 1'b1) begin bad++; $display("FAIL rnd_accept[%0d] got %0b want 1", n, ok); end
         total++; if (p != 1) begin bad++; $display("FAIL rnd_pulses[%0d] got %0d want 1", n, p); end
         total++; if (a1 !== a) begin bad++; $display("FAIL rnd_addr[%0d] got %0h want %0h", n, a1, a); end
         total++; if (r1 !== we) begin bad++; $display("FAIL rnd_rw[%0d] got %0b want %0b", n, r1, we); end
         if (we) begin
            ref_mem[a] = d;
            total++; if (d1 !== d) begin bad++; $display("FAIL rnd_wbus[%0d] got %0h want %0h", n, d1, d); end
            total++; if (k != WR_LAT) begin bad++; $display("FAIL rnd_wlat[%0d] got %0d want %0d", n, k, WR_LAT); end
         end else begin
            total++; if (rd !== ref_mem[a]) begin bad++; $display("FAIL rnd_rdata[%0d] got %0h want %0h", n, rd, ref_mem[a]); end
            total++; if (k != RD_LAT) begin bad++; $display("FAIL rnd_rlat[%0d] got %0d want %0d", n, k, RD_LAT); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_unwritten();
      test_back_to_back();
      test_reset_mid_read();
      test_write_then_read();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Master-side controller sitting directly upstream of memory32x8_bi, between the core's load/store path and the memory.
- Turns single read/write requests (valid/ready handshake) into the memory's en/rw/addr control and a shared tri-state 8-bit data bus.
- Returns captured read data with a one-cycle response strobe.
- Owns bus-direction control, so memory and core never drive the data bus at the same time.

Parameters:
- ADDR_W, 5, memory address width; 32 words.
- DATA_W, 8, data bus width.
- READ_WAIT, 1, extra cycles address is held before read data is sampled; legal range 0..7.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request this cycle.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  request address.
- req_wdata  input  DATA_W  write data.
- rsp_valid  output  1  one-cycle pulse on read or write completion.
- rsp_rdata  output  DATA_W  captured read data; holds its value until the next read capture.
- mem_en  output  1  memory enable.
- mem_rw  output  1  1 = write (controller drives bus), 0 = read (memory drives bus).
- mem_addr  output  ADDR_W  memory address.
- mem_data  inout  DATA_W  shared bidirectional data bus.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: synchronous and active-high; clock port is clk, reset port is rst.
  - Next edge with rst=1 forces IDLE.
  - mem_en=0, mem_rw=0, mem_addr=0, rsp_valid=0, rsp_rdata=0, read-wait counter=0.
  - mem_data released (high-Z); req_ready=1 once rst falls.
  - Any in-flight request is dropped with no response.
- All outputs are registered or decoded from state; no combinational path from req_* to mem_*.
- State machine:
  - IDLE: req_ready=1, mem_en=0, bus Z. On req_valid=1, latch addr, we and wdata. Go to WR if we=1, otherwise RD (counter=READ_WAIT).
  - WR: exactly one cycle. mem_en=1, mem_rw=1, mem_addr=latched address, mem_data driven with latched wdata. Memory writes at the closing edge. Next state is IDLE, or TURN when the feature is enabled. rsp_valid pulses in the following cycle.
  - RD: mem_en=1, mem_rw=0, mem_addr held, bus Z. Counter decrements each cycle. On the cycle where counter==0, the closing edge captures mem_data into rsp_rdata, then goes to IDLE with rsp_valid=1 for one cycle.
  - TURN (feature only): one cycle with mem_en=0, bus Z, req_ready=0, then IDLE.
- Latency, counted from the accept edge:
  - Write completes at edge +1; rsp_valid is high during cycle +1..+2.
  - Read: rsp_valid is high in cycle READ_WAIT+2. With default 1, the response is 3 cycles after acceptance.
- rsp_valid and a new acceptance can occur in the same IDLE cycle; back-to-back requests are allowed with no bubble (no bubble only without the feature).
- Bus drive rule: mem_data is driven only in WR, where mem_rw=1. Never driven in any other state or during reset.
- Address: no wrap or increment; ADDR_W bits are passed through. Address 31 is legal.
- req_* is ignored when req_ready=0; no request is queued.
- READ_WAIT=0: RD lasts one cycle and captures at its closing edge.

Optional Feature:
- Macro: MEM_CTRL_TURNAROUND_EN.
- Defined: WR is always followed by one TURN cycle (bus Z, en=0, req_ready=0) before IDLE. This guarantees one dead bus cycle between controller drive and any following memory drive. Write-to-next-accept spacing is 3 cycles.
- Undefined: WR goes straight to IDLE. Write-to-next-accept spacing is 2 cycles. TURN state logic is absent.

Test Plan:
- Write then read: write addr 1 = 0x02, then read addr 1.
  - WR cycle shows mem_en=1, mem_rw=1, mem_addr=1, mem_data=0x02.
  - Read gives rsp_rdata=0x02 with rsp_valid at accept+3.
- Unwritten location: read addr 2 after writing only addr 1 → rsp_rdata equals the memory's content at addr 2. During the RD cycles, mem_rw=0 and the controller does not drive the bus.
- Back-to-back: hold req_valid=1 for reads of addr 1, then addr 31 → two rsp_valid pulses 3 cycles apart, and req_ready low while busy.
- Reset mid-read: assert rst in the first RD cycle → next cycle is IDLE, mem_en=0, bus Z, rsp_rdata=0, and no rsp_valid pulse is ever produced for the dropped read.
- Turnaround (MEM_CTRL_TURNAROUND_EN defined): write then immediate read request → one TURN cycle with mem_en=0 and bus Z. The read is accepted at write-accept+3, and bus contention is never seen (no X on mem_data).
- READ_WAIT=0 build: read of addr 1 after a write of 0xA5 → rsp_rdata=0xA5 with rsp_valid at accept+2.
